// File: rtl/inv_delay_line.sv
// ---------------------------------------------------------------------------
// inv_delay_line
//   WIDTH-channel programmable delay line with optional inversion. Each channel
//   is a DEPTH-stage synchronous shift register. A tap mux picks stage dly_q,
//   and the result is registered onto out. The effective delay is dly+1 cycles.
//
//   Optional feature macro: INV_DLY_EDGE_CNT_EN
//     defined   -> edge_cnt counts out[0] toggles while valid is high
//                  (wraps at 16 bits; cleared by reset and by a delay change)
//     undefined -> edge_cnt is tied to zero and no counter logic is built
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous active-high reset
//   in        in   WIDTH  channel inputs, captured every edge
//   dly       in   DW     delay select (delay = dly+1 cycles)
//   invert    in   1      1: out is the inverted tap, 0: out is the plain tap
//   out       out  WIDTH  registered delayed channels
//   valid     out  1      out holds data captured after the last reset/delay change
//   edge_cnt  out  16     out[0] toggle count (zero when the feature is off)
// ---------------------------------------------------------------------------
module inv_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int DW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [DW-1:0]    dly,
  input  logic             invert,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic [15:0]      edge_cnt
);

  localparam logic [DW:0] FCNT_MAX = (DW+1)'(DEPTH);

  logic [WIDTH-1:0] sr_r [DEPTH];
  logic [DW-1:0]    dly_r;
  logic [DW:0]      fcnt_r;
  logic [WIDTH-1:0] out_r;
  logic             valid_r;

  logic [WIDTH-1:0] tap_s;
  logic             change_s;
  logic             valid_nxt_s;
  logic [DW:0]      fcnt_nxt_s;

  // Tap selection, delay-change detection and fill-counter next state
  always_comb begin
    tap_s       = sr_r[dly_r] ^ {WIDTH{invert}};
    change_s    = (dly != dly_r);
    // The tap holds post-change data only once more samples have been
    // captured since the change than the tap index.
    valid_nxt_s = (fcnt_r > {1'b0, dly_r}) && !change_s;
    if (change_s) begin
      fcnt_nxt_s = '0;
    end else if (fcnt_r != FCNT_MAX) begin
      fcnt_nxt_s = fcnt_r + {{DW{1'b0}}, 1'b1};
    end else begin
      fcnt_nxt_s = fcnt_r;
    end
  end

  // Shift register, delay register, fill counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        sr_r[k] <= '0;
      end
      dly_r   <= '0;
      fcnt_r  <= '0;
      out_r   <= '0;
      valid_r <= 1'b0;
    end else begin
      sr_r[0] <= in;
      for (int k = 1; k < DEPTH; k++) begin
        sr_r[k] <= sr_r[k-1];
      end
      dly_r   <= dly;
      fcnt_r  <= fcnt_nxt_s;
      out_r   <= tap_s;
      valid_r <= valid_nxt_s;
    end
  end

  assign out   = out_r;
  assign valid = valid_r;

`ifdef INV_DLY_EDGE_CNT_EN
  logic [15:0] edge_cnt_r;

  // out[0] toggle counter; an edge counts when valid is already high and out[0] is about to change
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cnt_r <= 16'h0000;
    end else if (change_s) begin
      edge_cnt_r <= 16'h0000;
    end else if (valid_r && (tap_s[0] != out_r[0])) begin
      edge_cnt_r <= edge_cnt_r + 16'h0001;
    end else begin
      edge_cnt_r <= edge_cnt_r;
    end
  end

  assign edge_cnt = edge_cnt_r;
`else
  assign edge_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_inv_delay_line.sv
// ---------------------------------------------------------------------------
// tb_inv_delay_line
//   Directed self-checking bench for inv_delay_line (WIDTH=8, DEPTH=16).
//   Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_inv_delay_line;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int DW    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_v;
  logic [DW-1:0]    dly;
  logic             invert;
  logic [WIDTH-1:0] out;
  logic             valid;
  logic [15:0]      edge_cnt;

  int checks   = 0;
  int failures = 0;

  inv_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in_v),
    .dly      (dly),
    .invert   (invert),
    .out      (out),
    .valid    (valid),
    .edge_cnt (edge_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One rising edge, then return at the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Settle at delay d, then send a one-cycle pulse and check where it lands
  task automatic run_pulse(input string tag, input logic [DW-1:0] d, input logic inv,
                           input logic [7:0] pv, input logic [7:0] bv, input int span);
    logic [7:0] exp_o;
    dly    = d;
    invert = inv;
    in_v   = bv;
    repeat (20) step();
    check_val({tag, "_valid_pre"}, {31'd0, valid}, 32'd1);
    in_v = pv;
    step();               // capture edge E
    in_v = bv;
    for (int j = 1; j <= span; j++) begin
      step();             // edge E+j
      exp_o = (j == int'(d) + 1) ? (pv ^ {8{inv}}) : (bv ^ {8{inv}});
      check_val(tag, {24'd0, out}, {24'd0, exp_o});
      check_val({tag, "_valid"}, {31'd0, valid}, 32'd1);
    end
  endtask

  initial begin
    reset  = 1'b1;
    in_v   = 8'hFF;
    invert = 1'b1;
    dly    = 4'd0;

    // Reset holds everything at zero regardless of in/invert
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("rst_out", {24'd0, out}, 32'h0);
      check_val("rst_valid", {31'd0, valid}, 32'd0);
      check_val("rst_edge_cnt", {16'd0, edge_cnt}, 32'h0);
    end

    // dly=0 from reset: first capture at E0, valid after E0+1
    reset  = 1'b0;
    invert = 1'b0;
    in_v   = 8'h3C;
    step();
    check_val("e0_out", {24'd0, out}, 32'h00);
    check_val("e0_valid", {31'd0, valid}, 32'd0);
    in_v = 8'hC3;
    step();
    check_val("e1_out", {24'd0, out}, 32'h3C);
    check_val("e1_valid", {31'd0, valid}, 32'd1);
    in_v = 8'h00;
    step();
    check_val("e2_out", {24'd0, out}, 32'hC3);

    // invert applies on the next out update
    invert = 1'b1;
    step();
    check_val("inv_out", {24'd0, out}, 32'hFF);

    run_pulse("fix3",  4'd3,  1'b1, 8'hA5, 8'h00, 8);
    run_pulse("min0",  4'd0,  1'b0, 8'h80, 8'h00, 4);
    run_pulse("max15", 4'd15, 1'b0, 8'h80, 8'h00, 20);

`ifndef INV_DLY_EDGE_CNT_EN
    check_val("edge_cnt_off", {16'd0, edge_cnt}, 32'h0);
`endif

    // Delay change 2 -> 7 seen at edge Ec
    dly    = 4'd2;
    invert = 1'b0;
    in_v   = 8'h11;
    repeat (20) step();
    check_val("chg_valid_pre", {31'd0, valid}, 32'd1);
    dly = 4'd7;
    step();               // Ec
    check_val("chg_valid_ec", {31'd0, valid}, 32'd0);
    in_v = 8'h22;         // first post-change capture at Ec+1
    for (int j = 1; j <= 12; j++) begin
      step();
      check_val("chg_valid", {31'd0, valid}, (j >= 9) ? 32'd1 : 32'd0);
      if (j >= 9) begin
        check_val("chg_out", {24'd0, out}, 32'h22);
      end
    end

    // Reset mid-stream at dly=5 discards in-flight data
    dly = 4'd5;
    for (int i = 0; i < 20; i++) begin
      in_v = 8'h40 + 8'(i);
      step();
    end
    check_val("mrst_valid_pre", {31'd0, valid}, 32'd1);
    reset = 1'b1;
    in_v  = 8'h77;
    step();
    check_val("mrst_out", {24'd0, out}, 32'h0);
    check_val("mrst_valid", {31'd0, valid}, 32'd0);
    check_val("mrst_edge_cnt", {16'd0, edge_cnt}, 32'h0);
    reset = 1'b0;
    in_v  = 8'h00;
    for (int j = 0; j < 20; j++) begin
      step();
      check_val("mrst_post_out", {24'd0, out}, 32'h0);
    end
    check_val("mrst_valid_post", {31'd0, valid}, 32'd1);

`ifdef INV_DLY_EDGE_CNT_EN
    // Toggle in[0] every cycle at dly=0; after post-reset edge k (k>=1) the
    // count is k-1 (mod 65536) and out[0] equals in[0] from edge k-1.
    reset  = 1'b1;
    dly    = 4'd0;
    invert = 1'b0;
    in_v   = 8'h00;
    step();
    reset = 1'b0;
    for (int k = 0; k < 70000; k++) begin
      in_v = {7'd0, k[0]};
      step();             // edge k
      if (k == 10 || k == 65536 || k == 65537 || k == 69999) begin
        check_val("ec_cnt", {16'd0, edge_cnt}, 32'(16'(k - 1)));
        check_val("ec_out0", {31'd0, out[0]}, {31'd0, ~k[0]});
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
